// File: rtl/axi_to_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_to_fifo_pkg
// Description : Shared header layout, state encoding and word builder for the
//               256-bit AXI-S to 201-bit FIFO word packer.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_to_fifo_pkg;

    localparam int VALID_BIT     = 0;
    localparam int LAST_BIT      = 1;
    localparam int TAG_LSB       = 2;
    localparam int CNT_LSB       = 4;
    localparam int DATA_LSB      = 9;
    localparam int WORD_WIDTH    = 201;
    localparam int PAYLOAD_WIDTH = 192;
    localparam int BEAT_WIDTH    = 256;

    localparam logic [4:0] CNT_FULL = 5'd31;

    localparam logic [1:0] TAG0 = 2'd0;
    localparam logic [1:0] TAG1 = 2'd1;
    localparam logic [1:0] TAG2 = 2'd2;
    localparam logic [1:0] TAG3 = 2'd3;

    typedef enum logic [1:0] {
        P0    = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2,
        EXTRA = 2'd3
    } state_e;

    // Concatenation order matches the DATA/CNT/TAG/LAST/VALID bit positions.
    function automatic logic [WORD_WIDTH-1:0] make_word(
        input logic [PAYLOAD_WIDTH-1:0] payload,
        input logic [4:0]               cnt,
        input logic [1:0]               tag,
        input logic                     last
    );
        make_word = {payload, cnt, tag, last, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_to_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_to_fifo_if
// Description : AXI4-Stream bundle feeding the packer (master = source).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_to_fifo_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 128,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH*8-1:0]   tdata;
    logic [TDATA_WIDTH-1:0]     tkeep;
    logic                       tlast;
    logic [TUSER_WIDTH-1:0]     tuser;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axi_to_fifo_keep_to_cnt.sv
`default_nettype none
// ============================================================================
// Module      : keep_to_cnt
// Description : Priority encoder, index of the highest set tkeep bit (0 if none).
// Revision    : 1.0 - initial release
// ============================================================================
module keep_to_cnt (
    input  wire logic [31:0] keep,
    output logic      [4:0]  idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (keep[i]) idx = i[4:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_to_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_to_fifo
// Description : Packs 256-bit AXI-S beats into 201-bit FIFO words (3 beats ->
//               4 words). Macro AXI_TO_FIFO_PKT_CNT_EN enables pkt_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_to_fifo
    import axi_to_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH         = 32,
    parameter int CROPPED_TDATA_WIDTH = 24,
    parameter int TUSER_WIDTH         = 128,
    parameter int TID_WIDTH           = 4,
    parameter int TDEST_WIDTH         = 4
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    axi_to_fifo_if.slave               s_axis,
    input  wire logic                  cal_done,
    input  wire logic                  fifo_full,
    input  wire logic                  fifo_almost_full,
    output logic                       fifo_winc,
    output logic [WORD_WIDTH-1:0]      fifo_wdata,
    output logic [31:0]                input_fifo_cnt,
    output logic [31:0]                pkt_cnt
);
    localparam int C_BEAT_BITS    = TDATA_WIDTH * 8;
    localparam int C_PAYLOAD_BITS = CROPPED_TDATA_WIDTH * 8;

    state_e                    state_q, state_d;
    logic                      run_q, run_d;
    logic [127:0]              residue_q, residue_d;
    logic [WORD_WIDTH-1:0]     extra_q, extra_d;
    logic                      winc_q, winc_d;
    logic [WORD_WIDTH-1:0]     wdata_q, wdata_d;
    logic [31:0]               in_cnt_q, in_cnt_d;

    logic [C_BEAT_BITS-1:0]    w_beat;
    logic [4:0]                w_keep_idx;
    logic [4:0]                w_kc;
    logic                      w_accept;
    logic                      w_tready;

    logic [TUSER_WIDTH+TID_WIDTH+TDEST_WIDTH-1:0] unused_side;
    logic [C_PAYLOAD_BITS-1:0]                    unused_payload_w;

    assign unused_side      = {s_axis.tuser, s_axis.tid, s_axis.tdest};
    assign unused_payload_w = '0;

    assign w_beat = s_axis.tdata;

    keep_to_cnt u_keep_to_cnt (
        .keep (s_axis.tkeep),
        .idx  (w_keep_idx)
    );

    // Only a packet's final beat carries a meaningful byte count.
    assign w_kc     = s_axis.tlast ? w_keep_idx : CNT_FULL;
    // run_q keeps tready low while reset is held, independent of cal_done.
    assign w_tready = run_q & cal_done & ~fifo_almost_full & (state_q != EXTRA);
    assign w_accept = s_axis.tvalid & w_tready;
    assign s_axis.tready = w_tready;

    always_comb begin
        state_d   = state_q;
        run_d     = 1'b1;
        residue_d = residue_q;
        extra_d   = extra_q;
        winc_d    = 1'b0;
        wdata_d   = wdata_q;
        in_cnt_d  = in_cnt_q;

        if (state_q == EXTRA) begin
            if (!fifo_full) begin
                winc_d  = 1'b1;
                wdata_d = extra_q;
                state_d = P0;
            end
        end else if (w_accept) begin
            winc_d   = 1'b1;
            in_cnt_d = in_cnt_q + 32'd1;
            case (state_q)
                P0: begin
                    wdata_d   = make_word(w_beat[191:0], 5'd0, TAG0, s_axis.tlast);
                    residue_d = {64'b0, w_beat[255:192]};
                    extra_d   = make_word({128'b0, w_beat[255:192]}, w_kc, TAG1, 1'b0);
                    state_d   = s_axis.tlast ? EXTRA : P1;
                end
                P1: begin
                    wdata_d   = make_word({w_beat[127:0], residue_q[63:0]}, CNT_FULL, TAG1, s_axis.tlast);
                    residue_d = w_beat[255:128];
                    extra_d   = make_word({64'b0, w_beat[255:128]}, w_kc, TAG2, 1'b0);
                    state_d   = s_axis.tlast ? EXTRA : P2;
                end
                default: begin
                    // P2 consumes the whole residue, so the beat always spills a second word.
                    wdata_d   = make_word({w_beat[63:0], residue_q}, CNT_FULL, TAG2, s_axis.tlast);
                    residue_d = '0;
                    extra_d   = make_word(w_beat[255:64], w_kc, TAG3, 1'b0);
                    state_d   = EXTRA;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= P0;
            run_q     <= 1'b0;
            residue_q <= '0;
            extra_q   <= '0;
            winc_q    <= 1'b0;
            wdata_q   <= '0;
            in_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            residue_q <= residue_d;
            extra_q   <= extra_d;
            winc_q    <= winc_d;
            wdata_q   <= wdata_d;
            in_cnt_q  <= in_cnt_d;
        end
    end

    assign fifo_winc      = winc_q;
    assign fifo_wdata     = wdata_q;
    assign input_fifo_cnt = in_cnt_q;

`ifdef AXI_TO_FIFO_PKT_CNT_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (w_accept && s_axis.tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pkt_cnt_q <= '0;
        else         pkt_cnt_q <= pkt_cnt_d;
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_to_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_to_fifo
// Description : Scoreboard bench for axi_to_fifo with directed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_to_fifo;
    logic         clk = 1'b0;
    logic         resetn;
    logic         cal_done;
    logic         fifo_full;
    logic         fifo_almost_full;
    logic         fifo_winc;
    logic [200:0] fifo_wdata;
    logic [31:0]  input_fifo_cnt;
    logic [31:0]  pkt_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [200:0] exp_q[$];

    axi_to_fifo_if bus ();

    axi_to_fifo dut (
        .clk              (clk),
        .resetn           (resetn),
        .s_axis           (bus),
        .cal_done         (cal_done),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_winc        (fifo_winc),
        .fifo_wdata       (fifo_wdata),
        .input_fifo_cnt   (input_fifo_cnt),
        .pkt_cnt          (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Payload byte i holds base+i for i < nbytes, zero above.
    function automatic logic [200:0] mk(input logic [7:0] base, input int nbytes,
                                        input logic [4:0] cnt, input logic [1:0] tag,
                                        input logic last);
        logic [191:0] p;
        logic [7:0]   b;
        p = '0;
        for (int i = 0; i < 24; i++) begin
            if (i < nbytes) begin
                b = base + i[7:0];
                p[8*i +: 8] = b;
            end
        end
        return {p, cnt, tag, last, 1'b1};
    endfunction

    task automatic check(input string name, input logic [200:0] got, input logic [200:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] base, input logic [31:0] keep, input logic last);
        logic [255:0] d;
        logic [7:0]   b;
        logic         ok;
        for (int i = 0; i < 32; i++) begin
            b = base + i[7:0];
            d[8*i +: 8] = b;
        end
        @(negedge clk);
        bus.tvalid = 1'b1;
        bus.tdata  = d;
        bus.tkeep  = keep;
        bus.tlast  = last;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.tready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1 bus.tvalid = 1'b0;
        end else begin
            bus.tvalid = 1'b0;
            check("beat_accept", 201'(ok), 201'd1);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 201'(exp_q.size()), 201'd0);
    endtask

    // Monitor: every FIFO write must match the head of the scoreboard.
    initial begin
        logic [200:0] e;
        forever begin
            @(negedge clk);
            if (fifo_winc === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write got=%0h exp=none", fifo_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_word", fifo_wdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        logic [31:0] exp_pkt;
        bus.tvalid = 1'b0;
        bus.tdata  = '0;
        bus.tkeep  = '0;
        bus.tlast  = 1'b0;
        bus.tuser  = '0;
        bus.tid    = '0;
        bus.tdest  = '0;
        resetn = 1'b0;
        cal_done = 1'b0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready", 201'(bus.tready), 201'd0);
        check("rst_winc", 201'(fifo_winc), 201'd0);
        check("rst_wdata", fifo_wdata, 201'd0);
        check("rst_in_cnt", 201'(input_fifo_cnt), 201'd0);
        check("rst_pkt_cnt", 201'(pkt_cnt), 201'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("tready_no_cal", 201'(bus.tready), 201'd0);
        cal_done = 1'b1;
        @(negedge clk);
        check("tready_cal", 201'(bus.tready), 201'd1);

        // 3-beat packet, bytes 0x00..0x5F
        exp_q.push_back(mk(8'h00, 24, 5'd0,  2'd0, 1'b0));
        exp_q.push_back(mk(8'h18, 24, 5'd31, 2'd1, 1'b0));
        exp_q.push_back(mk(8'h30, 24, 5'd31, 2'd2, 1'b1));
        exp_q.push_back(mk(8'h48, 24, 5'd31, 2'd3, 1'b0));
        send_beat(8'h00, 32'hFFFF_FFFF, 1'b0);
        send_beat(8'h20, 32'hFFFF_FFFF, 1'b0);
        send_beat(8'h40, 32'hFFFF_FFFF, 1'b1);
        drain();
        check("in_cnt_3", 201'(input_fifo_cnt), 201'd3);

        // 1-beat packet, half keep; tready low for one cycle
        exp_q.push_back(mk(8'h80, 24, 5'd0,  2'd0, 1'b1));
        exp_q.push_back(mk(8'h98, 8,  5'd15, 2'd1, 1'b0));
        send_beat(8'h80, 32'h0000_FFFF, 1'b0 | 1'b1);
        lows = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.tready !== 1'b1) lows++;
        end
        check("tready_low_cycles", 201'(lows), 201'd1);
        drain();

        // 2-beat packet with 8-byte tail, then a fresh packet from tag 0
        exp_q.push_back(mk(8'h20, 24, 5'd0,  2'd0, 1'b0));
        exp_q.push_back(mk(8'h38, 24, 5'd31, 2'd1, 1'b1));
        exp_q.push_back(mk(8'h50, 16, 5'd7,  2'd2, 1'b0));
        exp_q.push_back(mk(8'h60, 24, 5'd0,  2'd0, 1'b1));
        exp_q.push_back(mk(8'h78, 8,  5'd31, 2'd1, 1'b0));
        send_beat(8'h20, 32'hFFFF_FFFF, 1'b0);
        send_beat(8'h40, 32'h0000_00FF, 1'b1);
        send_beat(8'h60, 32'hFFFF_FFFF, 1'b1);
        drain();
        check("in_cnt_7", 201'(input_fifo_cnt), 201'd7);

        // EXTRA stalled by fifo_full for 5 cycles
        exp_q.push_back(mk(8'hA0, 24, 5'd0, 2'd0, 1'b1));
        exp_q.push_back(mk(8'hB8, 8,  5'd0, 2'd1, 1'b0));
        send_beat(8'hA0, 32'h0000_0001, 1'b1);
        @(negedge clk);
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_winc", 201'(fifo_winc), 201'd0);
            check("stall_tready", 201'(bus.tready), 201'd0);
        end
        fifo_full = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Async reset between beat 1 and beat 2
        exp_q.push_back(mk(8'hC0, 24, 5'd0, 2'd0, 1'b0));
        send_beat(8'hC0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_winc", 201'(fifo_winc), 201'd0);
        check("arst_tready", 201'(bus.tready), 201'd0);
        check("arst_wdata", fifo_wdata, 201'd0);
        check("arst_in_cnt", 201'(input_fifo_cnt), 201'd0);
        check("arst_pkt_cnt", 201'(pkt_cnt), 201'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.push_back(mk(8'h10, 24, 5'd0,  2'd0, 1'b1));
        exp_q.push_back(mk(8'h28, 8,  5'd11, 2'd1, 1'b0));
        exp_q.push_back(mk(8'h30, 24, 5'd0,  2'd0, 1'b1));
        exp_q.push_back(mk(8'h48, 8,  5'd30, 2'd1, 1'b0));
        send_beat(8'h10, 32'h0000_0FFF, 1'b1);
        send_beat(8'h30, 32'h7FFF_FFFF, 1'b1);
        drain();
`ifdef AXI_TO_FIFO_PKT_CNT_EN
        exp_pkt = 32'd2;
`else
        exp_pkt = 32'd0;
`endif
        check("final_pkt_cnt", 201'(pkt_cnt), 201'(exp_pkt));
        check("final_in_cnt", 201'(input_fifo_cnt), 201'd2);

        repeat (5) @(negedge clk);
        check("queue_empty", 201'(exp_q.size()), 201'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_to_fifo.md
Name: axi_to_fifo

Overview:
- Write-side packer for the memory-backed packet buffer.
- Accepts 256-bit (32-byte) AXI4-Stream beats and crops them into 192-bit (24-byte) payload words, each with a 9-bit header; total word width is 201 bits.
- Writes the words into the async FIFO toward the memory controller.
- Three input beats pack into four words. The header lets the downstream FIFO-to-AXI reassembler rebuild the original beats and tlast/tstrb.

Parameters:
- TDATA_WIDTH, 32, AXI data width in bytes. Only 32 is supported.
- CROPPED_TDATA_WIDTH, 24, payload bytes per FIFO word. Only 24 is supported.
- TUSER_WIDTH, 128, tuser width in bits. Ignored.
- TID_WIDTH, 4, tid width. Ignored.
- TDEST_WIDTH, 4, tdest width. Ignored.

Ports:
- clk  in  1  single clock for stream and FIFO write side
- resetn  in  1  asynchronous, active-low reset
- tvalid  in  1  AXI-S valid
- tready  out  1  AXI-S ready
- tdata  in  256  AXI-S data
- tkeep  in  32  AXI-S byte enables; contiguous from bit 0
- tlast  in  1  end of packet
- tuser  in  TUSER_WIDTH  ignored
- tid  in  TID_WIDTH  ignored
- tdest  in  TDEST_WIDTH  ignored
- cal_done  in  1  memory calibration complete
- fifo_full  in  1  FIFO full
- fifo_almost_full  in  1  FIFO has at most 2 free entries
- fifo_winc  out  1  FIFO write strobe
- fifo_wdata  out  201  FIFO write word
- input_fifo_cnt  out  32  count of beats accepted
- pkt_cnt  out  32  count of packets accepted (optional feature)

Behaviour:
- Word layout:
  - [200:9] payload.
  - [8:4] cnt: highest valid byte index of the beat this word completes.
  - [3:2] phase tag.
  - [1] last: the beat completed by the next word is a packet's last beat.
  - [0] valid, always 1.
- Reset (resetn=0, asynchronous) clears everything: tready=0, fifo_winc=0, fifo_wdata=0, input_fifo_cnt=0, pkt_cnt=0, phase=P0, residue=0.
- States: P0, P1, P2, EXTRA. EXTRA holds the second word of an accepted beat.
- tready = cal_done & ~fifo_almost_full & (state != EXTRA).
- A beat is accepted when tvalid & tready. On accept, the first word is registered: fifo_winc=1 on the following cycle.
- kc = index of the highest set tkeep bit when tlast=1; otherwise 31.
- Accept in P0:
  - Word = {beat[191:0]}, tag 0, cnt 0, last = tlast.
  - Residue = beat[255:192].
  - tlast=0: go to P1.
  - tlast=1: go to EXTRA. The extra word is {128'b0, beat[255:192]}, tag 1, cnt kc, last 0. Next phase P0.
- Accept in P1:
  - Word = {beat[127:0], residue[63:0]}, tag 1, cnt 31, last = tlast.
  - Residue = beat[255:128].
  - tlast=0: go to P2.
  - tlast=1: go to EXTRA. The extra word is {64'b0, beat[255:128]}, tag 2, cnt kc, last 0. Next phase P0.
- Accept in P2 always takes two words:
  - First word = {beat[63:0], residue[127:0]}, tag 2, cnt 31, last = tlast.
  - Extra word = beat[255:64], tag 3, cnt kc, last 0.
  - Next phase P0.
- EXTRA: the extra word is written on the first cycle with fifo_full=0. Then move to the stored next phase. While fifo_full=1, fifo_winc=0 and the block stays in EXTRA.
- A packet always ends with phase back at P0. The next packet starts at tag 0.
- input_fifo_cnt increments per accepted beat and wraps at 2^32.
- No write occurs when there is no accept and no EXTRA. fifo_winc is held 0 and fifo_wdata holds its value.
- cal_done deasserted mid-packet: tready drops. Pending EXTRA still completes.
- Reset mid-packet: the partial packet is discarded and no further writes occur.

Optional Feature:
- Macro AXI_TO_FIFO_PKT_CNT_EN.
  - Defined: pkt_cnt increments on each accepted beat with tlast=1, wrapping at 2^32.
  - Undefined: pkt_cnt is tied to 0 and no counter is built.

Decomposition:
- Package axi_to_fifo_pkg holds:
  - header bit positions (VALID_BIT=0, LAST_BIT=1, TAG_LSB=2, CNT_LSB=4, DATA_LSB=9);
  - WORD_WIDTH=201;
  - phase/state encodings;
  - CNT_FULL=31.
- Sub-module keep_to_cnt: 32-bit tkeep to 5-bit highest-set-index priority encoder, purely combinational.

Test Plan:
- Reset with cal_done=0: tready=0, fifo_winc=0. Raise cal_done: tready=1 next cycle.
- 3-beat packet, full tkeep, data bytes 0x00..0x5F: four words with tags 0,1,2,3. cnt values 0,31,31,31. last bit set on the tag-2 word only. Reassembled bytes match the input. input_fifo_cnt=3.
- 1-beat packet, tkeep=0x0000FFFF: word0 (tag 0, last=1), then word1 = {128'b0, beat[255:192]}, tag 1, cnt 15. tready=0 for exactly one cycle.
- 2-beat packet, second beat tkeep=0x000000FF: three words with tags 0,1,2. Tag-1 word has last=1. Tag-2 word has cnt=7 and upper 64 payload bits 0. A following packet starts at tag 0.
- In EXTRA with fifo_full=1 for 5 cycles: no write and tready=0. On release, the extra word is written exactly once.
- Async reset asserted between beat 1 and beat 2: outputs clear immediately. The next packet starts at tag 0. With AXI_TO_FIFO_PKT_CNT_EN defined, pkt_cnt reads 0 after reset and 2 after two packets; undefined, it reads 0.
